// File: rtl/cpu_pkg.sv
// Shared types for the 16-bit lab CPU front end: widths, fetch FSM states and
// the fetch-buffer entry layout.
package cpu_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 16;

  typedef enum logic [1:0] {
    S_ISSUE,
    S_WAIT,
    S_DROP
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] sext_disp(input logic [7:0] disp);
    return ADDR_W'($signed(disp));
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Two-entry synchronous FIFO of fetched {addr, instr} pairs. Flush empties it
// without touching storage; push on a full FIFO is accepted only with a pop.
module ifetch_fifo
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [1:0]   count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem_q [2];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   count_q;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign full  = (count_q == 2'd2);
  assign empty = (count_q == 2'd0);

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: owns the PC, keeps one read in flight to instruction
// memory, buffers returns in a 2-entry FIFO and redirects on jmp/br.
module ifetch #(
  parameter int unsigned       ADDR_W   = cpu_pkg::ADDR_W,
  parameter int unsigned       DATA_W   = cpu_pkg::DATA_W,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jmp,
  input  logic              br,
  input  logic [7:0]        imm,
  input  logic [7:0]        disp,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] pc
);
  import cpu_pkg::*;

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic [ADDR_W-1:0] req_addr_q;

  fetch_entry_t      head;
  fetch_entry_t      wdata;
  logic [1:0]        count;
  logic              full;
  logic              empty;

  logic              consume;
  logic              redirect;
  logic              push;
  logic              space_after;
  logic [ADDR_W-1:0] target;

  assign consume  = instr_valid && !stall;
  assign redirect = consume && (jmp || br);
  assign target   = jmp ? imm : pc + sext_disp(disp);

  // A response that races a redirect belongs to the old stream and is dropped.
  assign push        = (state_q == S_WAIT) && imem_rvalid && !redirect;
  assign space_after = ({1'b0, count} + 3'd1 - {2'b00, consume}) < 3'd2;
  assign wdata       = '{addr: req_addr_q, instr: imem_rdata};

  always_comb begin
    imem_req = 1'b0;
    if (!rst) begin
      unique case (state_q)
        S_ISSUE: imem_req = !full;
        S_WAIT:  imem_req = push && space_after;
        default: imem_req = 1'b0;
      endcase
    end
  end

  assign imem_addr = fetch_pc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_ISSUE;
      fetch_pc_q <= RESET_PC;
      req_addr_q <= '0;
    end else begin
      if (imem_req) begin
        fetch_pc_q <= fetch_pc_q + ADDR_W'(1);
        req_addr_q <= fetch_pc_q;
      end
      if (redirect) begin
        fetch_pc_q <= target;
      end
      unique case (state_q)
        S_ISSUE: begin
          // A request issued alongside a redirect is already stale.
          if (imem_req) state_q <= redirect ? S_DROP : S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) state_q <= (push && space_after) ? S_WAIT : S_ISSUE;
          else if (redirect) state_q <= S_DROP;
        end
        S_DROP: begin
          if (imem_rvalid) state_q <= S_ISSUE;
        end
        default: state_q <= S_ISSUE;
      endcase
    end
  end

  ifetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst | redirect),
    .flush (redirect),
    .push  (push),
    .wdata (wdata),
    .pop   (consume),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign instr_valid = !empty;
  assign instruction = empty ? '0 : head.instr;
  assign pc          = empty ? '0 : head.addr;

endmodule

// File: tb/tb_ifetch.sv
// Bench for ifetch: in-order variable-latency memory, a queue-based reference
// model checked every cycle, directed scenarios plus a randomized soak.
module tb_ifetch;

  typedef struct {
    logic [7:0]  addr;
    logic [15:0] instr;
  } ent_t;

  typedef struct {
    int         due;
    logic [7:0] addr;
  } mreq_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        jmp = 1'b0;
  logic        br = 1'b0;
  logic        stall = 1'b0;
  logic [7:0]  imm = 8'h00;
  logic [7:0]  disp = 8'h00;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = 16'h0000;
  logic        instr_valid;
  logic [15:0] instruction;
  logic [7:0]  pc;

  always #5 clk = ~clk;

  ifetch dut (
    .clk         (clk),
    .rst         (rst),
    .jmp         (jmp),
    .br          (br),
    .imm         (imm),
    .disp        (disp),
    .stall       (stall),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .instr_valid (instr_valid),
    .instruction (instruction),
    .pc          (pc)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int lat_min = 1;
  int lat_max = 1;

  logic [15:0] imem [256];
  mreq_t       mq[$];

  // Reference model: buffered entries, next fetch address, one in-flight read.
  ent_t        m_q[$];
  logic [7:0]  m_fpc = 8'h00;
  logic [7:0]  m_paddr = 8'h00;
  bit          m_pend = 1'b0;
  bit          m_disc = 1'b0;

  logic [7:0]  d_pc[$];
  logic [15:0] d_instr[$];
  logic [7:0]  r_addr[$];
  logic        s_req, s_valid;
  logic [7:0]  s_addr, s_pc;
  logic [15:0] s_instr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    bit         e_valid, cons, redir, resp, acc, e_req;
    logic [7:0] e_pc, tgt;
    logic [15:0] e_instr;
    @(negedge clk);
    e_valid = (m_q.size() > 0);
    e_pc    = e_valid ? m_q[0].addr : 8'h00;
    e_instr = e_valid ? m_q[0].instr : 16'h0000;
    cons    = !rst && e_valid && !stall;
    redir   = cons && (jmp || br);
    // 8-bit add wraps mod 256, identical to a sign-extended displacement.
    tgt     = jmp ? imm : e_pc + disp;
    resp    = imem_rvalid && m_pend;
    acc     = resp && !m_disc && !redir;
    if (rst) e_req = 1'b0;
    else if (!m_pend) e_req = (m_q.size() < 2);
    else e_req = acc && ((m_q.size() + 1 - (cons ? 1 : 0)) < 2);

    chk("instr_valid", 32'(instr_valid), 32'(e_valid));
    chk("instruction", 32'(instruction), 32'(e_instr));
    chk("pc", 32'(pc), 32'(e_pc));
    chk("imem_req", 32'(imem_req), 32'(e_req));
    if (e_req) chk("imem_addr", 32'(imem_addr), 32'(m_fpc));

    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
    s_instr = instruction; s_pc = pc;
    if (instr_valid === 1'b1 && !stall && !rst) begin
      d_pc.push_back(pc);
      d_instr.push_back(instruction);
    end
    if (imem_req === 1'b1) begin
      r_addr.push_back(imem_addr);
      mq.push_back('{cyc + int'($urandom_range(lat_max, lat_min)), imem_addr});
    end

    @(posedge clk);
    if (rst) begin
      m_q.delete();
      m_fpc = 8'h00; m_pend = 1'b0; m_disc = 1'b0;
    end else begin
      if (cons) void'(m_q.pop_front());
      if (acc) m_q.push_back('{m_paddr, imem_rdata});
      if (redir) m_q.delete();
      if (resp) begin m_pend = 1'b0; m_disc = 1'b0; end
      if (e_req) begin m_pend = 1'b1; m_paddr = m_fpc; m_fpc = m_fpc + 8'd1; end
      if (redir) begin m_fpc = tgt; if (m_pend) m_disc = 1'b1; end
    end
    cyc++;
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'($urandom);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = imem[mq[0].addr];
      void'(mq.pop_front());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; stall = 1'b0; jmp = 1'b0; br = 1'b0; imm = 8'h00; disp = 8'h00;
    mq.delete();
    step();
    rst = 1'b0;
    d_pc.delete(); d_instr.delete(); r_addr.delete();
  endtask

  task automatic chk_deliv(input string tag, input int idx, input logic [7:0] epc);
    if (idx < d_pc.size()) begin
      chk({tag, "_pc"}, 32'(d_pc[idx]), 32'(epc));
      chk({tag, "_instr"}, 32'(d_instr[idx]), 32'(16'hA000 + 16'(epc)));
    end else begin
      chk({tag, "_count"}, d_pc.size(), idx + 1);
    end
  endtask

  initial begin
    int n_req;
    int phase;
    bit done;
    for (int i = 0; i < 256; i++) imem[i] = 16'hA000 + 16'(i);
    repeat (2) @(posedge clk);
    #1;

    // Reset state and sequential fetch with a 1-cycle memory.
    do_reset();
    chk("rst_valid", 32'(s_valid), 0);
    chk("rst_instr", 32'(s_instr), 0);
    chk("rst_pc", 32'(s_pc), 0);
    chk("rst_req", 32'(s_req), 0);
    lat_min = 1; lat_max = 1;
    step(); chk("seq_req0", 32'(s_req), 1); chk("seq_addr0", 32'(s_addr), 0);
    step(); chk("seq_early", 32'(s_valid), 0); chk("seq_addr1", 32'(s_addr), 1);
    step(); chk("seq_valid", 32'(s_valid), 1); chk("seq_i0", 32'(s_instr), 32'h0000A000);
    chk("seq_pc0", 32'(s_pc), 0); chk("seq_addr2", 32'(s_addr), 2);
    step(); chk("seq_i1", 32'(s_instr), 32'h0000A001); chk("seq_pc1", 32'(s_pc), 1);
    step(); chk("seq_i2", 32'(s_instr), 32'h0000A002); chk("seq_pc2", 32'(s_pc), 2);

    // Back-pressure: two fetches then idle, head holds.
    do_reset();
    stall = 1'b1;
    repeat (8) step();
    chk("bp_nreq", r_addr.size(), 2);
    if (r_addr.size() >= 2) begin
      chk("bp_a0", 32'(r_addr[0]), 0);
      chk("bp_a1", 32'(r_addr[1]), 1);
    end
    chk("bp_req_idle", 32'(s_req), 0);
    chk("bp_head_i", 32'(s_instr), 32'h0000A000);
    chk("bp_head_pc", 32'(s_pc), 0);
    stall = 1'b0;
    repeat (8) step();
    for (int i = 0; i < 3; i++) chk_deliv("bp_order", i, 8'(i));

    // jmp while the fetch of addr 2 is in flight (3-cycle memory).
    do_reset();
    lat_min = 3; lat_max = 3;
    done = 1'b0; n_req = 0;
    for (int i = 0; i < 40; i++) begin
      jmp = !done && m_q.size() > 0 && m_q[0].addr == 8'h01;
      imm = 8'h40;
      step();
      if (jmp) begin done = 1'b1; n_req = r_addr.size(); end
    end
    jmp = 1'b0;
    chk("jmp_seen", 32'(done), 1);
    chk("jmp_inflight2", (n_req == 3 && r_addr[2] == 8'h02) ? 1 : 0, 1);
    if (r_addr.size() > n_req) chk("jmp_next_req", 32'(r_addr[n_req]), 32'h40);
    else chk("jmp_next_req_cnt", r_addr.size(), n_req + 1);
    chk_deliv("jmp_d1", 1, 8'h01);
    chk_deliv("jmp_d2", 2, 8'h40);

    // Branch backwards with wrap, then jmp+br together (jmp wins).
    do_reset();
    lat_min = 1; lat_max = 1;
    phase = 0;
    for (int i = 0; i < 40; i++) begin
      jmp = 1'b0; br = 1'b0;
      if (phase == 0 && m_q.size() > 0 && m_q[0].addr == 8'h02) begin
        br = 1'b1; disp = 8'hFC; phase = 1;
      end else if (phase == 1 && m_q.size() > 0 && m_q[0].addr == 8'h00) begin
        jmp = 1'b1; imm = 8'h10; br = 1'b1; disp = 8'h05; phase = 2;
      end
      step();
    end
    jmp = 1'b0; br = 1'b0;
    chk_deliv("br_d2", 2, 8'h02);
    chk_deliv("br_fe", 3, 8'hFE);
    chk_deliv("br_ff", 4, 8'hFF);
    chk_deliv("br_wrap", 5, 8'h00);
    chk_deliv("prio", 6, 8'h10);

    // jmp while stalled must be ignored.
    do_reset();
    for (int i = 0; i < 20 && !(m_q.size() > 0 && m_q[0].addr == 8'h01); i++) step();
    stall = 1'b1; jmp = 1'b1; imm = 8'h80;
    repeat (3) step();
    stall = 1'b0; jmp = 1'b0;
    repeat (6) step();
    chk_deliv("gate_d1", 1, 8'h01);
    chk_deliv("gate_d2", 2, 8'h02);

    // Reset with one entry buffered and a fetch outstanding; late data lands after reset.
    do_reset();
    lat_min = 3; lat_max = 3;
    stall = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 30 && !done; i++) begin
      if (m_q.size() == 1 && mq.size() > 0 && mq[0].due == cyc + 1) done = 1'b1;
      else step();
    end
    chk("mid_setup", 32'(done), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    d_pc.delete(); d_instr.delete();
    step();
    chk("mid_valid", 32'(s_valid), 0);
    chk("mid_req", 32'(s_req), 1);
    chk("mid_addr", 32'(s_addr), 0);
    stall = 1'b0;
    repeat (12) step();
    chk_deliv("mid_d0", 0, 8'h00);
    chk_deliv("mid_d1", 1, 8'h01);

    // Randomized soak against the model.
    do_reset();
    for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(99, 0) < 30);
      jmp   = ($urandom_range(99, 0) < 8);
      br    = ($urandom_range(99, 0) < 10);
      imm   = 8'($urandom);
      disp  = 8'($urandom);
      step();
    end
    chk("rand_progress", (d_pc.size() > 300) ? 1 : 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
